// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter
//   Sends one command byte from the host to a PS/2 device using the
//   request-to-send sequence. The sequence is:
//     inhibit clock -> start bit -> 8 data bits + odd parity + stop -> ACK slot.
//   The outcome is reported as ACK, NACK (ack_error) or timeout.
//   The keyboard receive path shares PS2_CLK/PS2_DAT and must ignore the bus
//   while busy=1.
//
// Parameters
//   INHIBIT_CYCLES  cycles PS2_CLK is held low before the request
//   TIMEOUT_CYCLES  cycle budget from REQ until the bus returns idle
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   cmd_data/cmd_valid    byte to send (LSB first); accepted when cmd_ready=1
//   cmd_ready             high only in IDLE
//   busy                  high in every state except IDLE
//   done                  1-cycle pulse at the end of a transaction
//   ack_error, timeout    result flags; valid with done, held until next command
//   PS2_CLK, PS2_DAT      open-drain pins: driven 0 or released (z)
//
// Configuration
//   PS2_TX_RETRY_EN  when defined, a NACK or timeout on the first attempt
//                    triggers exactly one retry with the latched byte.
module ps2_host_transmitter #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   output logic       busy,
   output logic       done,
   output logic       ack_error,
   output logic       timeout,
   inout  wire        PS2_CLK,
   inout  wire        PS2_DAT
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE
   } state_t;

   state_t          state, state_next;
   logic [1:0]      clk_sync, dat_sync;
   logic            clk_prev;
   logic            sclk, sdat, fall;
   logic [7:0]      data_q;
   logic            par_q;
   logic [3:0]      bitcnt;
   logic [IW-1:0]   icnt;
   logic [TW-1:0]   tcnt;
   logic            dat_low;
   logic            retried;
   logic            retry_ok;
   logic            expire;
   logic            inhibit_end;
   logic            tx_bit;
   logic            clk_drive_low, dat_drive_low;

   assign sclk = clk_sync[1];
   assign sdat = dat_sync[1];
   assign fall = clk_prev & ~sclk;

`ifdef PS2_TX_RETRY_EN
   assign retry_ok = ~retried;
`else
   assign retry_ok = 1'b0;
`endif

   // Timeout budget only runs from REQ until WAIT_IDLE exits.
   assign expire = (tcnt == TW'(TIMEOUT_CYCLES - 1)) &&
                   (state == REQ || state == SEND || state == ACK || state == WAIT_IDLE);

   assign inhibit_end = (icnt == IW'(INHIBIT_CYCLES - 1));

   // Bit presented on the fall where bitcnt has its current value:
   // 0..7 data, 8 parity, 9 stop (released).
   always_comb begin
      tx_bit = 1'b1;
      if (bitcnt < 4'd8)       tx_bit = data_q[bitcnt[2:0]];
      else if (bitcnt == 4'd8) tx_bit = par_q;
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (cmd_valid) state_next = INHIBIT;
         INHIBIT:   if (inhibit_end) state_next = REQ;
         REQ:       state_next = SEND;
         SEND:      if (fall && bitcnt == 4'd9) state_next = ACK;
         ACK:       if (fall) state_next = (sdat && retry_ok) ? INHIBIT : WAIT_IDLE;
         WAIT_IDLE: if (sclk && sdat) state_next = DONE;
         DONE:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
      // Expiry overrides any bus event in the same cycle.
      if (expire) state_next = retry_ok ? INHIBIT : DONE;
   end

   // Output logic
   always_comb begin
      cmd_ready     = (state == IDLE);
      busy          = (state != IDLE);
      done          = (state == DONE);
      clk_drive_low = (state == INHIBIT);
      dat_drive_low = (state == REQ) || (state == SEND && dat_low);
   end

   assign PS2_CLK = clk_drive_low ? 1'b0 : 1'bz;
   assign PS2_DAT = dat_drive_low ? 1'b0 : 1'bz;

   // Datapath: synchronisers, counters, shift control, result flags
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         dat_sync  <= 2'b11;
         clk_prev  <= 1'b1;
         data_q    <= '0;
         par_q     <= 1'b0;
         bitcnt    <= '0;
         icnt      <= '0;
         tcnt      <= '0;
         dat_low   <= 1'b0;
         retried   <= 1'b0;
         ack_error <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], PS2_CLK};
         dat_sync <= {dat_sync[0], PS2_DAT};
         clk_prev <= sclk;

         icnt <= (state == INHIBIT) ? icnt + 1'b1 : '0;

         if (state == IDLE || state == INHIBIT) tcnt <= '0;
         else if (!expire)                       tcnt <= tcnt + 1'b1;

         if (state == IDLE && cmd_valid) begin
            data_q    <= cmd_data;
            par_q     <= ~^cmd_data;
            ack_error <= 1'b0;
            timeout   <= 1'b0;
            retried   <= 1'b0;
         end

         if (state == REQ) begin
            bitcnt  <= '0;
            dat_low <= 1'b1;  // start bit held until the first fall
         end

         if (state == SEND && fall && !expire) begin
            bitcnt  <= bitcnt + 1'b1;
            dat_low <= ~tx_bit;
         end

         // NACK at the ACK slot; a retry (if allowed) hides the first failure.
         if (state == ACK && fall && sdat && !expire) begin
            if (retry_ok) retried   <= 1'b1;
            else          ack_error <= 1'b1;
         end

         if (expire) begin
            if (retry_ok) retried <= 1'b1;
            else          timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
module tb_ps2_host_transmitter;

   localparam int INH = 20;
   localparam int TMO = 4000;
`ifdef PS2_TX_RETRY_EN
   localparam int TMO_TOTAL = 2 * TMO + INH;
`else
   localparam int TMO_TOTAL = TMO;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready, busy, done, ack_error, timeout;
   wire        ps2_clk, ps2_dat;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;

   pullup (ps2_clk);
   pullup (ps2_dat);
   assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
   assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

   ps2_host_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .busy(busy), .done(done), .ack_error(ack_error),
      .timeout(timeout), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   logic [9:0] exp_frame[$];   // {stop, parity, data[7:0]}
   logic [1:0] exp_res[$];     // {ack_error, timeout}

   always @(negedge clock) if (done === 1'b1) done_cnt <= done_cnt + 1;

   initial begin
      #600000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clock);
      chk("ready_before_cmd", cmd_ready, 1);
      cmd_data  = b;
      cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   // Counts cycles with PS2_CLK low until the request (CLK high, DAT low).
   task automatic wait_req(output int low, output bit ok);
      low = 0;
      ok  = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (ps2_clk === 1'b0) low++;
         else if (ps2_dat === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      chk("req_seen", ok, 1);
   endtask

   // Device: 60-cycle clock, samples DAT on the rising edge, then the ACK slot.
   task automatic dev_frame(input bit nack, output logic [9:0] fr);
      fr = '0;
      repeat (20) @(negedge clock);
      for (int k = 0; k < 10; k++) begin
         dev_clk_low = 1'b1;
         repeat (30) @(negedge clock);
         dev_clk_low = 1'b0;
         fr[k] = ps2_dat;
         repeat (30) @(negedge clock);
      end
      dev_dat_low = ~nack;
      repeat (15) @(negedge clock);
      dev_clk_low = 1'b1;
      repeat (30) @(negedge clock);
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
   endtask

   task automatic check_frame(input logic [9:0] fr);
      logic [9:0] e;
      chk("sb_frame_pending", exp_frame.size() > 0, 1);
      if (exp_frame.size() > 0) begin
         e = exp_frame.pop_front();
         chk("frame", fr, e);
      end
   endtask

   task automatic wait_done(input int limit, output int n);
      logic [1:0] e;
      n = 0;
      while (done !== 1'b1 && n < limit) begin
         @(negedge clock);
         n++;
      end
      chk("done_seen", done, 1);
      chk("ready_during_done", cmd_ready, 0);
      chk("clk_released_at_done", ps2_clk, 1);
      chk("dat_released_at_done", ps2_dat, 1);
      chk("sb_res_pending", exp_res.size() > 0, 1);
      if (exp_res.size() > 0) begin
         e = exp_res.pop_front();
         chk("ack_error", ack_error, e[1]);
         chk("timeout", timeout, e[0]);
      end
      @(negedge clock);
      chk("ready_after_done", cmd_ready, 1);
   endtask

   initial begin
      logic [9:0] fr;
      int low, n, dsave, clk_lows;
      bit ok;

      // Reset state
      repeat (3) @(negedge clock);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ack_error", ack_error, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_clk_z", ps2_clk, 1);
      chk("rst_dat_z", ps2_dat, 1);
      reset = 1'b0;

      // 1: 0xED, ACK
      exp_frame.push_back(10'h3ED);
      exp_res.push_back(2'b00);
      send(8'hED);
      chk("busy_after_accept", busy, 1);
      wait_req(low, ok);
      chk("inhibit_len", low, INH);
      dev_frame(1'b0, fr);
      check_frame(fr);
      wait_done(500, n);

      // 2: 0xF4, parity 0
      exp_frame.push_back(10'h2F4);
      exp_res.push_back(2'b00);
      send(8'hF4);
      wait_req(low, ok);
      chk("inhibit_len_f4", low, INH);
      dev_frame(1'b0, fr);
      check_frame(fr);
      wait_done(500, n);

      // 3: 0xFF, NACK
      dsave = done_cnt;
`ifdef PS2_TX_RETRY_EN
      exp_frame.push_back(10'h3FF);
      exp_frame.push_back(10'h3FF);
      exp_res.push_back(2'b00);
      send(8'hFF);
      wait_req(low, ok);
      dev_frame(1'b1, fr);
      check_frame(fr);
      chk("no_done_between_attempts", done_cnt, dsave);
      wait_req(low, ok);
      dev_frame(1'b0, fr);
      check_frame(fr);
`else
      exp_frame.push_back(10'h3FF);
      exp_res.push_back(2'b10);
      send(8'hFF);
      wait_req(low, ok);
      dev_frame(1'b1, fr);
      check_frame(fr);
`endif
      wait_done(500, n);
      @(negedge clock);
      chk("single_done_nack", done_cnt, dsave + 1);

      // 4: device never clocks
      exp_res.push_back(2'b01);
      send(8'hED);
      wait_req(low, ok);
      wait_done(TMO_TOTAL + 500, n);
      chk("timeout_cycles", n, TMO_TOTAL);

      // 5: reset after the 5th fall
      dsave = done_cnt;
      send(8'hED);
      wait_req(low, ok);
      repeat (20) @(negedge clock);
      repeat (4) begin
         dev_clk_low = 1'b1;
         repeat (30) @(negedge clock);
         dev_clk_low = 1'b0;
         repeat (30) @(negedge clock);
      end
      dev_clk_low = 1'b1;
      repeat (10) @(negedge clock);
      dev_clk_low = 1'b0;
      chk("dat_driven_before_reset", ps2_dat, 0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_clk_z", ps2_clk, 1);
      chk("abort_dat_z", ps2_dat, 1);
      chk("abort_ready", cmd_ready, 1);
      chk("abort_busy", busy, 0);
      repeat (50) @(negedge clock);
      chk("abort_no_done", done_cnt, dsave);

      exp_frame.push_back(10'h3ED);
      exp_res.push_back(2'b00);
      send(8'hED);
      wait_req(low, ok);
      chk("inhibit_len_after_abort", low, INH);
      dev_frame(1'b0, fr);
      check_frame(fr);
      wait_done(500, n);

      // 6: cmd_valid pulse while busy is ignored
      exp_frame.push_back(10'h3ED);
      exp_res.push_back(2'b00);
      send(8'hED);
      wait_req(low, ok);
      fork
         dev_frame(1'b0, fr);
         begin
            repeat (200) @(negedge clock);
            chk("ready_low_in_send", cmd_ready, 0);
            cmd_data  = 8'h00;
            cmd_valid = 1'b1;
            @(negedge clock);
            cmd_valid = 1'b0;
         end
      join
      check_frame(fr);
      wait_done(500, n);
      clk_lows = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (ps2_clk === 1'b0) clk_lows++;
      end
      chk("no_second_txn", clk_lows, 0);
      chk("sb_frames_drained", exp_frame.size(), 0);
      chk("done_count", done_cnt, 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
